// File: rtl/insn_fetch.sv
// Instruction fetch / pre-decode stage: walks the code ROM one window per instruction,
// splits out opcode and decoded immediate, and presents them over a valid/ready handshake.
module insn_fetch #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  input  logic                          redirect_valid,
  input  logic [MEM_DEPTH:0]            redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    opcode,
  output logic [63:0]                   immediate,
  output logic [3:0]                    length,
  output logic [MEM_DEPTH:0]            pc,
  output logic [3:0]                    trap
);

  localparam int WIN_BITS = (2**MEM_EXTRA) * 8;
  localparam int DEC_BITS = 88;

  localparam logic [3:0] TRAP_NONE = 4'd0;
  localparam logic [3:0] TRAP_MEM  = 4'd1;
  localparam logic [3:0] TRAP_LEB  = 4'd2;

  if (MEM_EXTRA < 4) begin : gBadExtra
    $error("insn_fetch: MEM_EXTRA must be >= 4 so a window holds the longest instruction");
  end

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_TRAP
  } stateT;

  typedef struct packed {
    logic [63:0] value;
    logic [3:0]  len;
    logic        malformed;
  } lebT;

  // LEB128 payload starts at window byte 1; len counts the opcode byte too.
  function automatic lebT decodeLeb(input logic [DEC_BITS-1:0] win,
                                    input int maxBytes,
                                    input logic isSigned);
    lebT        r;
    logic       done;
    logic [7:0] b;
    r    = '0;
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b = win[8*(i+1) +: 8];
      if (!done && (i < maxBytes)) begin
        r.value = r.value | (64'(b[6:0]) << (7*i));
        r.len   = 4'(i + 2);
        if (!b[7]) begin
          done = 1'b1;
          if (isSigned && b[6] && (7*(i+1) < 64)) begin
            r.value = r.value | ({64{1'b1}} << (7*(i+1)));
          end
        end
      end
    end
    r.malformed = !done;
    return r;
  endfunction

  stateT              state_q, state_d;
  logic [MEM_DEPTH:0] fetchPc_q, fetchPc_d;
  logic [MEM_DEPTH:0] pcOut_q, pcOut_d;
  logic               valid_q, valid_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [63:0]        imm_q, imm_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         trap_q, trap_d;

  logic [DEC_BITS-1:0] win;
  logic [7:0]          decOp;
  logic [63:0]         decImm;
  logic [3:0]          decLen;
  logic                decBad;
  lebT                 lebS5, lebS10, lebU5;

  assign win = mem_data[DEC_BITS-1:0];

  if (WIN_BITS > DEC_BITS) begin : gTail
    logic unusedWindowTail;
    assign unusedWindowTail = ^mem_data[WIN_BITS-1:DEC_BITS];
  end

  assign lebS5  = decodeLeb(win, 5, 1'b1);
  assign lebS10 = decodeLeb(win, 10, 1'b1);
  assign lebU5  = decodeLeb(win, 5, 1'b0);

  always_comb begin
    decOp  = win[7:0];
    decImm = '0;
    decLen = 4'd1;
    decBad = 1'b0;
    case (decOp)
      8'h41: begin
        decImm = lebS5.value;
        decLen = lebS5.len;
        decBad = lebS5.malformed;
      end
      8'h42: begin
        decImm = lebS10.value;
        decLen = lebS10.len;
        decBad = lebS10.malformed;
      end
      8'h43: begin
        decImm = {32'b0, win[39:8]};
        decLen = 4'd5;
      end
      8'h44: begin
        decImm = win[71:8];
        decLen = 4'd9;
      end
      8'h0C, 8'h0D, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24: begin
        decImm = lebU5.value;
        decLen = lebU5.len;
        decBad = lebU5.malformed;
      end
      8'h02, 8'h03, 8'h04: begin
        decImm = {56'b0, win[15:8]};
        decLen = 4'd2;
      end
      default: begin
        decImm = '0;
        decLen = 4'd1;
      end
    endcase
  end

  // Redirect outranks everything except a trap, including a same-cycle accept.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    pcOut_d   = pcOut_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    len_d     = len_q;
    trap_d    = trap_q;
    if ((state_q != S_TRAP) && redirect_valid) begin
      fetchPc_d = redirect_pc;
      valid_d   = 1'b0;
      state_d   = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (mem_error) begin
            trap_d  = TRAP_MEM;
            state_d = S_TRAP;
          end else if (decBad) begin
            trap_d  = TRAP_LEB;
            state_d = S_TRAP;
          end else begin
            opcode_d = decOp;
            imm_d    = decImm;
            len_d    = decLen;
            pcOut_d  = fetchPc_q;
            valid_d  = 1'b1;
            state_d  = S_VALID;
          end
        end
        S_VALID: begin
          if (valid_q && out_ready) begin
            fetchPc_d = fetchPc_q + (MEM_DEPTH+1)'(len_q);
            valid_d   = 1'b0;
            state_d   = S_FETCH;
          end
        end
        S_TRAP: valid_d = 1'b0;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      fetchPc_q <= '0;
      pcOut_q   <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      imm_q     <= '0;
      len_q     <= '0;
      trap_q    <= TRAP_NONE;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      pcOut_q   <= pcOut_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      len_q     <= len_d;
      trap_q    <= trap_d;
    end
  end

  assign mem_addr  = fetchPc_q;
  assign mem_extra = '1;
  assign out_valid = valid_q;
  assign opcode    = opcode_q;
  assign immediate = imm_q;
  assign length    = len_q;
  assign pc        = pcOut_q;
  assign trap      = trap_q;

endmodule
